if_fetch_buffer: RTL and testbench

Instruction-fetch stage sitting directly downstream of the program counter and upstream of decode. Issues the current PC to instruction memory over a valid/ready request channel and pairs each returned instruction with its PC. Queues fetched instructions in a small FIFO that presents a valid/ready interface to decode. Generates the PC's advance enable, and discards stale work on a branch redirect (flush).

---
 rtl/if_fetch_buffer_if.sv | 30 +++
 rtl/if_fetch_buffer.sv | 115 +++++++++++
 tb/tb_if_fetch_buffer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_buffer_if.sv
// Fetch-stage bundle: PC hookup, instruction-memory request/response and
// the decode-side valid/ready port. The fetch buffer uses the master view;
// the surrounding PC, memory and decode logic use the slave view.
interface if_fetch_buffer_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic [PC_WIDTH-1:0]    pc;
    logic                   pc_en;
    logic                   flush;
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [PC_WIDTH-1:0]    imem_req_addr;
    logic                   imem_rsp_valid;
    logic [INSTR_WIDTH-1:0] imem_rsp_data;
    logic                   id_valid;
    logic [INSTR_WIDTH-1:0] id_instr;
    logic [PC_WIDTH-1:0]    id_pc;
    logic                   id_ready;

    modport master (
        input  pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
        output pc_en, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc
    );

    modport slave (
        output pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
        input  pc_en, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc
    );
endinterface

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch buffer: issues the PC to instruction memory, pairs each
// returned word with the PC it was fetched from, and queues the pairs for
// decode. A redirect (flush) empties the queue and discards any response
// still in flight.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | no request outstanding
// WAIT      | one request outstanding, its response is kept
// WAIT_DROP | one request outstanding, its response is dropped
module if_fetch_buffer #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 2
) (
    input logic              clk,
    input logic              rst,
    if_fetch_buffer_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT      = 2'd1,
        WAIT_DROP = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       count;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PC_WIDTH-1:0]    tag;
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];

    logic reserved;
    logic room;
    logic req_valid;
    logic fire;
    logic push;
    logic pop;
    logic head_valid;

    // Request gating: a slot stays reserved for the outstanding WAIT response,
    // so a new request only goes out when its response is guaranteed a slot.
    always_comb begin
        reserved   = (state == WAIT);
        room       = ({1'b0, count} + SUM_W'(reserved)) < SUM_W'(DEPTH);
        req_valid  = !rst && !bus.flush && ((state == IDLE) || bus.imem_rsp_valid) && room;
        fire       = req_valid && bus.imem_req_ready;
        push       = !rst && (state == WAIT) && bus.imem_rsp_valid && !bus.flush;
        head_valid = !rst && (count != '0);
        pop        = head_valid && bus.id_ready;
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = bus.pc;
    assign bus.pc_en          = fire || (bus.flush && !rst);
    assign bus.id_valid       = head_valid;
    assign bus.id_instr       = instr_mem[rd_ptr];
    assign bus.id_pc          = pc_mem[rd_ptr];

    // Request FSM, PC tag capture and FIFO bookkeeping; flush outranks everything but reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            tag    <= '0;
        end else if (bus.flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            if ((state == IDLE) || bus.imem_rsp_valid) begin
                state <= IDLE;
            end else begin
                state <= WAIT_DROP;
            end
        end else begin
            if (fire) begin
                tag <= bus.pc;
            end
            case (state)
                IDLE: begin
                    if (fire) state <= WAIT;
                end
                WAIT, WAIT_DROP: begin
                    if (bus.imem_rsp_valid) state <= fire ? WAIT : IDLE;
                end
                default: state <= IDLE;
            endcase
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage; contents only matter while counted, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= bus.imem_rsp_data;
            pc_mem[wr_ptr]    <= tag;
        end
    end

    // The reserved slot must keep every push off a full queue.
    assert property (@(posedge clk) disable iff (rst) push |-> (count < CNT_W'(DEPTH)));
endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: a PC register and a fixed-latency memory model
// surround the DUT; a scoreboard queues {pc, instr} on each accepted request
// and compares on each decode pop. A cycle table plus hand sequences cover
// stalls, redirects and mid-operation reset.
module tb_if_fetch_buffer;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] TGT      = 32'hBFC0_0100;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    typedef struct {
        logic        rst, fl, rdy, idr;
        logic        rv, pe, iv;
        logic [31:0] pc;
    } vec_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_q = RESET_PC;
    logic [31:0] target = TGT;
    logic        rsp_v = 1'b0;
    logic [31:0] rsp_d = '0;
    int          lat = 1;
    int          cyc = 0;
    int          n_total = 0;
    int          n_bad = 0;

    logic        s_fire = 1'b0, s_flush = 1'b0, s_rst = 1'b1, s_pc_en = 1'b0;
    logic [31:0] s_addr = '0, s_target = TGT;

    mreq_t mem_q[$];
    exp_t  exp_q[$];
    exp_t  sb_e;
    vec_t  tbl[17];

    if_fetch_buffer_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    if_fetch_buffer #(.PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.pc             = pc_q;
    assign bus.imem_rsp_valid = rsp_v;
    assign bus.imem_rsp_data  = rsp_d;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs just after the edge, return at mid-cycle for sampling.
    task automatic drive(input logic r, input logic fl, input logic rd, input logic ir);
        @(posedge clk);
        #1;
        rst                = r;
        bus.flush          = fl;
        bus.imem_req_ready = rd;
        bus.id_ready       = ir;
        @(negedge clk);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 4; i++) drive(H, L, L, H);
    endtask

    task automatic wait_id(input string name, input logic [31:0] exp_pc);
        int n = 0;
        while (!bus.id_valid && n < 12) begin
            drive(L, L, H, H);
            n++;
        end
        if (!bus.id_valid) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: id_valid never rose, got 0 expected 1", name);
        end else begin
            check({name, " id_pc"}, bus.id_pc, exp_pc);
            check({name, " id_instr"}, bus.id_instr, mem_word(exp_pc));
        end
    endtask

    // PC register and memory: react at the edge to what was sampled mid-cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (s_rst) pc_q <= RESET_PC;
        else if (s_pc_en) pc_q <= s_flush ? s_target : pc_q + 32'd4;
        if (s_fire) mem_q.push_back('{s_addr, cyc + lat});
        rsp_v <= 1'b0;
        if (mem_q.size() > 0 && mem_q[0].due == cyc + 1) begin
            rsp_v <= 1'b1;
            rsp_d <= mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
    end

    // Mid-cycle monitor: snapshot for the models and scoreboard bookkeeping.
    always @(negedge clk) begin
        s_fire   <= bus.imem_req_valid && bus.imem_req_ready;
        s_addr   <= bus.imem_req_addr;
        s_pc_en  <= bus.pc_en;
        s_flush  <= bus.flush;
        s_rst    <= rst;
        s_target <= target;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.id_valid && bus.id_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL sb_pop: got id_pc %h expected no entry", bus.id_pc);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb id_pc", bus.id_pc, sb_e.pc);
                    check("sb id_instr", bus.id_instr, sb_e.instr);
                end
            end
            if (bus.flush) exp_q.delete();
            if (bus.imem_req_valid && bus.imem_req_ready)
                exp_q.push_back('{bus.imem_req_addr, mem_word(bus.imem_req_addr)});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // rst, flush, req_ready, id_ready | req_valid, pc_en, id_valid, id_pc
        tbl[0]  = '{H, L, H, H, L, L, L, 32'h0};
        tbl[1]  = '{L, L, H, H, H, H, L, 32'h0};
        tbl[2]  = '{L, L, H, H, H, H, L, 32'h0};
        tbl[3]  = '{L, L, H, H, L, L, H, 32'hBFC0_0000};
        tbl[4]  = '{L, L, H, H, H, H, H, 32'hBFC0_0004};
        tbl[5]  = '{L, L, H, H, H, H, L, 32'h0};
        tbl[6]  = '{L, L, H, L, L, L, H, 32'hBFC0_0008};
        tbl[7]  = '{L, L, H, L, L, L, H, 32'hBFC0_0008};
        tbl[8]  = '{L, L, H, L, L, L, H, 32'hBFC0_0008};
        tbl[9]  = '{L, L, H, H, L, L, H, 32'hBFC0_0008};
        tbl[10] = '{L, L, H, H, H, H, H, 32'hBFC0_000C};
        tbl[11] = '{L, L, H, H, H, H, L, 32'h0};
        tbl[12] = '{L, H, H, H, L, H, H, 32'hBFC0_0010};
        tbl[13] = '{L, L, H, H, H, H, L, 32'h0};
        tbl[14] = '{L, L, H, H, H, H, L, 32'h0};
        tbl[15] = '{L, L, H, H, L, L, H, 32'hBFC0_0100};
        tbl[16] = '{L, L, H, H, H, H, H, 32'hBFC0_0104};

        bus.flush          = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.id_ready       = 1'b0;

        // Cycle table: start-up, back-pressure fill/drain, redirect with coincident response.
        lat    = 1;
        target = TGT;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rst, tbl[i].fl, tbl[i].rdy, tbl[i].idr);
            check1($sformatf("tbl%0d req_valid", i), bus.imem_req_valid, tbl[i].rv);
            check1($sformatf("tbl%0d pc_en", i), bus.pc_en, tbl[i].pe);
            check1($sformatf("tbl%0d id_valid", i), bus.id_valid, tbl[i].iv);
            if (tbl[i].iv) check($sformatf("tbl%0d id_pc", i), bus.id_pc, tbl[i].pc);
        end

        // Request stall: address holds, no advance, single advance on accept.
        lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(L, L, L, H);
            check1("stall req_valid", bus.imem_req_valid, 1'b1);
            check1("stall pc_en", bus.pc_en, 1'b0);
            check("stall addr", bus.imem_req_addr, RESET_PC);
        end
        drive(L, L, H, H);
        check1("accept pc_en", bus.pc_en, 1'b1);
        check("accept addr", bus.imem_req_addr, RESET_PC);
        drive(L, L, L, H);
        check("after accept addr", bus.imem_req_addr, RESET_PC + 32'd4);
        check1("after accept pc_en", bus.pc_en, 1'b0);
        drive(L, L, L, H);
        check("held addr", bus.imem_req_addr, RESET_PC + 32'd4);
        drive(L, L, L, H);

        // 3-cycle memory, redirect the cycle after accept: late response dropped.
        lat = 3;
        do_reset();
        drive(L, L, H, H);
        check1("drop fire", bus.pc_en, 1'b1);
        target = TGT;
        drive(L, H, H, H);
        check1("drop flush req_valid", bus.imem_req_valid, 1'b0);
        check1("drop flush pc_en", bus.pc_en, 1'b1);
        drive(L, L, H, H);
        check1("drop wait req_valid", bus.imem_req_valid, 1'b0);
        check("drop wait addr", bus.imem_req_addr, TGT);
        drive(L, L, H, H);
        check1("drop rsp refire", bus.imem_req_valid, 1'b1);
        drive(L, L, H, H);
        check1("drop no push", bus.id_valid, 1'b0);
        wait_id("drop first", TGT);

        // Redirect coincident with a response that would fill the queue.
        lat = 1;
        do_reset();
        drive(L, L, H, L);
        drive(L, L, H, L);
        target = 32'hBFC0_0200;
        drive(L, H, H, L);
        check1("full flush id_valid", bus.id_valid, 1'b1);
        check("full flush id_pc", bus.id_pc, RESET_PC);
        check1("full flush req_valid", bus.imem_req_valid, 1'b0);
        drive(L, L, L, L);
        check1("post flush id_valid", bus.id_valid, 1'b0);
        check1("post flush idle req_valid", bus.imem_req_valid, 1'b1);
        check("post flush addr", bus.imem_req_addr, 32'hBFC0_0200);
        check1("post flush pc_en", bus.pc_en, 1'b0);

        // Reset while one entry is queued and one request is outstanding.
        lat = 3;
        do_reset();
        drive(L, L, H, L);
        drive(L, L, H, L);
        drive(L, L, H, L);
        drive(L, L, H, L);
        check1("rst pre fire", bus.pc_en, 1'b1);
        drive(L, L, H, L);
        check1("rst pre id_valid", bus.id_valid, 1'b1);
        drive(H, L, L, L);
        check1("in rst id_valid", bus.id_valid, 1'b0);
        check1("in rst req_valid", bus.imem_req_valid, 1'b0);
        check1("in rst pc_en", bus.pc_en, 1'b0);
        drive(L, L, L, L);
        check1("stale rsp id_valid", bus.id_valid, 1'b0);
        drive(L, L, L, L);
        check1("stale ignored id_valid", bus.id_valid, 1'b0);
        check("restart addr", bus.imem_req_addr, RESET_PC);
        drive(L, L, H, H);
        wait_id("restart", RESET_PC);

        // Random traffic per latency; scoreboard checks every pop.
        for (int ph = 1; ph <= 3; ph++) begin
            for (int i = 0; i < 5; i++) drive(L, L, L, H);
            lat = ph;
            for (int k = 0; k < 150; k++) begin
                target = 32'hBFC0_0000 + 32'($urandom_range(0, 255)) * 32'd4;
                drive(L, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) != 0);
            end
        end
        for (int i = 0; i < 10; i++) drive(L, L, L, H);
        check("drain leftover", 32'(exp_q.size()), 32'd0);
        check1("drain id_valid", bus.id_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
